// File: rtl/cpu_pkg.sv
// Shared types for the ID/EX boundary: ALU opcodes, the registered ID/EX record and its bubble value.
// Widths are fixed by the 32-bit ALU and the 32-entry GRF.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        LUI = 4'd2
    } alu_opt_e;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  rs_val;
        logic [DATA_W-1:0]  rt_val;
        logic [RADDR_W-1:0] rs_addr;
        logic [RADDR_W-1:0] rt_addr;
        logic [RADDR_W-1:0] rd;
        logic               reg_we;
        logic [15:0]        imm;
        logic               ext_sign;
        logic               alu_src;
        logic [3:0]         opt;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic sign);
        return sign ? {{16{imm[15]}}, imm} : {16'b0, imm};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields, pipeline control, MEM/WB forwarding taps and EX operand outputs.
// master drives ID/control/forwarding, slave is the stage itself.
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic               id_valid;
    logic               id_stall;
    logic               ex_hold;
    logic               flush;
    logic [DATA_W-1:0]  id_pc;
    logic [DATA_W-1:0]  id_rs_val;
    logic [DATA_W-1:0]  id_rt_val;
    logic [RADDR_W-1:0] id_rs_addr;
    logic [RADDR_W-1:0] id_rt_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic               id_reg_we;
    logic [15:0]        id_imm16;
    logic               id_ext_sign;
    logic               id_alu_src;
    logic [3:0]         id_alu_opt;

    logic               mem_we;
    logic [RADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0]  mem_val;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]  wb_val;

    logic               ex_valid;
    logic [DATA_W-1:0]  ex_pc;
    logic [DATA_W-1:0]  ex_v1;
    logic [DATA_W-1:0]  ex_v2;
    logic [15:0]        ex_imm;
    logic [3:0]         ex_opt;
    logic [DATA_W-1:0]  ex_rt_fwd;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_reg_we;

    modport master (
        output id_valid, id_stall, ex_hold, flush, id_pc, id_rs_val, id_rt_val,
               id_rs_addr, id_rt_addr, id_rd_addr, id_reg_we, id_imm16, id_ext_sign,
               id_alu_src, id_alu_opt, mem_we, mem_rd, mem_val, wb_we, wb_rd, wb_val,
        input  ex_valid, ex_pc, ex_v1, ex_v2, ex_imm, ex_opt, ex_rt_fwd, ex_rd, ex_reg_we
    );

    modport slave (
        input  id_valid, id_stall, ex_hold, flush, id_pc, id_rs_val, id_rt_val,
               id_rs_addr, id_rt_addr, id_rd_addr, id_reg_we, id_imm16, id_ext_sign,
               id_alu_src, id_alu_opt, mem_we, mem_rd, mem_val, wb_we, wb_rd, wb_val,
        output ex_valid, ex_pc, ex_v1, ex_v2, ex_imm, ex_opt, ex_rt_fwd, ex_rd, ex_reg_we
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand bypass: newest producer (MEM) beats WB, $0 never forwards; purely combinational, no backpressure.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  stored,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]  mem_val,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_val,
    output logic [DATA_W-1:0]  value
);

    always_comb begin
        value = stored;
        if (addr != '0) begin
            if (mem_we && mem_rd == addr) begin
                value = mem_val;
            end else if (wb_we && wb_rd == addr) begin
                value = wb_val;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with EX-side forwarding; one-cycle ID->EX latency, forwarded operands same-cycle.
// Priority flush > ex_hold > id_stall > load; hold keeps the instruction but re-latches forwarded rs/rt.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    id_ex_t            r;
    id_ex_t            r_next;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    fwd_mux u_fwd_rs (
        .addr    (r.rs_addr),
        .stored  (r.rs_val),
        .mem_we  (bus.mem_we),
        .mem_rd  (bus.mem_rd),
        .mem_val (bus.mem_val),
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_val  (bus.wb_val),
        .value   (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .addr    (r.rt_addr),
        .stored  (r.rt_val),
        .mem_we  (bus.mem_we),
        .mem_rd  (bus.mem_rd),
        .mem_val (bus.mem_val),
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_val  (bus.wb_val),
        .value   (fwd_rt)
    );

    always_comb begin
        r_next = r;
        if (bus.flush) begin
            r_next = BUBBLE;
        end else if (bus.ex_hold) begin
            // Latch the bypassed values so a producer leaving WB mid-freeze is not lost.
            r_next.rs_val = fwd_rs;
            r_next.rt_val = fwd_rt;
        end else if (bus.id_stall) begin
            r_next = BUBBLE;
        end else begin
            r_next = '{
                valid:    bus.id_valid,
                pc:       bus.id_pc,
                rs_val:   bus.id_rs_val,
                rt_val:   bus.id_rt_val,
                rs_addr:  bus.id_rs_addr,
                rt_addr:  bus.id_rt_addr,
                rd:       bus.id_rd_addr,
                reg_we:   bus.id_reg_we,
                imm:      bus.id_imm16,
                ext_sign: bus.id_ext_sign,
                alu_src:  bus.id_alu_src,
                opt:      bus.id_alu_opt
            };
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= BUBBLE;
        end else begin
            r <= r_next;
        end
    end

    always_comb begin
        bus.ex_valid  = r.valid;
        bus.ex_pc     = r.pc;
        bus.ex_v1     = fwd_rs;
        bus.ex_v2     = r.alu_src ? ext_imm(r.imm, r.ext_sign) : fwd_rt;
        bus.ex_imm    = r.imm;
        bus.ex_opt    = r.opt;
        bus.ex_rt_fwd = fwd_rt;
        bus.ex_rd     = r.rd;
        bus.ex_reg_we = r.reg_we & r.valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed corner cases then randomized traffic against an instruction-level model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model of the instruction sitting in EX
    logic        m_valid;
    logic [31:0] m_pc, m_rs, m_rt;
    logic [4:0]  m_rsa, m_rta, m_rd;
    logic        m_we, m_sx, m_src;
    logic [15:0] m_imm;
    logic [3:0]  m_opt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] s);
        if (a == 0) return s;
        if (bus.mem_we && bus.mem_rd == a) return bus.mem_val;
        if (bus.wb_we && bus.wb_rd == a) return bus.wb_val;
        return s;
    endfunction

    function automatic logic [31:0] ref_v2();
        int unsigned v;
        if (!m_src) return ref_fwd(m_rta, m_rt);
        v = m_imm;
        if (m_sx && m_imm >= 16'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_rsa = 0; m_rta = 0; m_rd = 0;
        m_we = 0; m_sx = 0; m_src = 0; m_imm = 0; m_opt = 0;
    endtask

    task automatic model_edge();
        if (!rst_n || bus.flush) begin
            model_clear();
        end else if (bus.ex_hold) begin
            m_rs = ref_fwd(m_rsa, m_rs);
            m_rt = ref_fwd(m_rta, m_rt);
        end else if (bus.id_stall) begin
            model_clear();
        end else begin
            m_valid = bus.id_valid; m_pc = bus.id_pc; m_rs = bus.id_rs_val; m_rt = bus.id_rt_val;
            m_rsa = bus.id_rs_addr; m_rta = bus.id_rt_addr; m_rd = bus.id_rd_addr;
            m_we = bus.id_reg_we; m_sx = bus.id_ext_sign; m_src = bus.id_alu_src;
            m_imm = bus.id_imm16; m_opt = bus.id_alu_opt;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  32'(bus.ex_valid),  32'(m_valid));
        check({tag, ".pc"},     bus.ex_pc,          m_pc);
        check({tag, ".v1"},     bus.ex_v1,          ref_fwd(m_rsa, m_rs));
        check({tag, ".v2"},     bus.ex_v2,          ref_v2());
        check({tag, ".imm"},    32'(bus.ex_imm),    32'(m_imm));
        check({tag, ".opt"},    32'(bus.ex_opt),    32'(m_opt));
        check({tag, ".rt_fwd"}, bus.ex_rt_fwd,      ref_fwd(m_rta, m_rt));
        check({tag, ".rd"},     32'(bus.ex_rd),     32'(m_rd));
        check({tag, ".reg_we"}, 32'(bus.ex_reg_we), 32'(m_valid & m_we));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] rsa, input logic [31:0] rsv,
                            input logic [4:0] rta, input logic [31:0] rtv, input logic [15:0] imm,
                            input logic sx, input logic src, input logic [3:0] opt);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs_addr = rsa; bus.id_rs_val = rsv;
        bus.id_rt_addr = rta; bus.id_rt_val = rtv; bus.id_rd_addr = rta; bus.id_reg_we = 1;
        bus.id_imm16 = imm; bus.id_ext_sign = sx; bus.id_alu_src = src; bus.id_alu_opt = opt;
    endtask

    task automatic drive_random_id();
        bus.id_valid = 1'($urandom); bus.id_pc = $urandom;
        bus.id_rs_addr = 5'($urandom_range(0, 3)); bus.id_rt_addr = 5'($urandom_range(0, 3));
        bus.id_rs_val = (bus.id_rs_addr == 0) ? 32'd0 : $urandom;
        bus.id_rt_val = (bus.id_rt_addr == 0) ? 32'd0 : $urandom;
        bus.id_rd_addr = 5'($urandom); bus.id_reg_we = 1'($urandom);
        bus.id_imm16 = 16'($urandom); bus.id_ext_sign = 1'($urandom);
        bus.id_alu_src = 1'($urandom); bus.id_alu_opt = 4'($urandom_range(0, 2));
    endtask

    task automatic clear_fwd();
        bus.mem_we = 0; bus.mem_rd = 0; bus.mem_val = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_val = 0;
    endtask

    initial begin
        bus.id_stall = 0; bus.ex_hold = 0; bus.flush = 0;
        drive_id(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 16'h0, 1'b0, 1'b0, 4'd0);
        bus.id_valid = 0; bus.id_reg_we = 0;
        clear_fwd();
        model_clear();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // Immediate extension
        drive_id(32'h400, 5'd8, 32'h99, 5'd9, 32'h77, 16'hFFFE, 1'b1, 1'b1, ADD);
        tick();
        @(negedge clk);
        check("addiu_v2", bus.ex_v2, 32'hFFFF_FFFE);
        check_all("addiu");
        drive_id(32'h404, 5'd8, 32'h99, 5'd9, 32'h77, 16'h8000, 1'b0, 1'b1, ADD);
        tick();
        @(negedge clk);
        check("ori_v2", bus.ex_v2, 32'h0000_8000);
        check_all("ori");

        // MEM beats WB, WB used when MEM drops out
        bus.mem_we = 1; bus.mem_rd = 8; bus.mem_val = 32'h11;
        bus.wb_we = 1; bus.wb_rd = 8; bus.wb_val = 32'h22;
        #1 check("fwd_mem", bus.ex_v1, 32'h11);
        bus.mem_we = 0;
        #1 check("fwd_wb", bus.ex_v1, 32'h22);
        clear_fwd();

        // $0 never forwards
        drive_id(32'h408, 5'd0, 32'h0, 5'd9, 32'h77, 16'h1, 1'b0, 1'b0, SUB);
        tick();
        @(negedge clk);
        bus.mem_we = 1; bus.mem_rd = 0; bus.mem_val = 32'hDEAD;
        bus.wb_we = 1; bus.wb_rd = 0; bus.wb_val = 32'hBEEF;
        #1 check("zero_guard", bus.ex_v1, 32'h0);
        clear_fwd();

        // Hold refresh: producer visible in WB only on the first frozen cycle
        drive_id(32'h40C, 5'd3, 32'h33, 5'd9, 32'h77, 16'h0, 1'b0, 1'b0, ADD);
        tick();
        bus.ex_hold = 1;
        bus.wb_we = 1; bus.wb_rd = 9; bus.wb_val = 32'h55;
        drive_random_id();
        @(negedge clk);
        check("hold_c1", bus.ex_rt_fwd, 32'h55);
        tick();
        bus.wb_we = 0;
        drive_random_id();
        @(negedge clk);
        check("hold_c2", bus.ex_rt_fwd, 32'h55);
        check_all("hold_c2");
        tick();
        @(negedge clk);
        check("hold_c3", bus.ex_rt_fwd, 32'h55);
        check("hold_pc", bus.ex_pc, 32'h40C);
        tick();
        bus.ex_hold = 0;
        clear_fwd();

        // Stall bubbles, hold beats stall, flush beats hold
        drive_id(32'h410, 5'd1, 32'h1, 5'd2, 32'h2, 16'h5, 1'b0, 1'b1, ADD);
        bus.id_stall = 1;
        tick();
        @(negedge clk);
        check("stall_valid", 32'(bus.ex_valid), 32'd0);
        check("stall_we", 32'(bus.ex_reg_we), 32'd0);
        bus.id_stall = 0;
        tick();
        drive_id(32'h414, 5'd1, 32'h1, 5'd2, 32'h2, 16'h5, 1'b0, 1'b1, SUB);
        bus.id_stall = 1; bus.ex_hold = 1;
        tick();
        @(negedge clk);
        check("stallhold_pc", bus.ex_pc, 32'h410);
        check("stallhold_valid", 32'(bus.ex_valid), 32'd1);
        bus.id_stall = 0; bus.flush = 1;
        tick();
        @(negedge clk);
        check("flushhold_valid", 32'(bus.ex_valid), 32'd0);
        check_all("flushhold");
        bus.flush = 0; bus.ex_hold = 0;

        // Asynchronous reset mid-stream
        drive_id(32'h418, 5'd1, 32'h1, 5'd2, 32'h2, 16'h5, 1'b0, 1'b1, LUI);
        tick();
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        rst_n = 0;
        #1;
        check("arst_valid", 32'(bus.ex_valid), 32'd0);
        check("arst_we", 32'(bus.ex_reg_we), 32'd0);
        check("arst_opt", 32'(bus.ex_opt), 32'd0);
        model_clear();
        check_all("arst");
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_random_id();
            bus.flush    = ($urandom_range(0, 15) == 0);
            bus.ex_hold  = ($urandom_range(0, 3) == 0);
            bus.id_stall = ($urandom_range(0, 4) == 0);
            bus.mem_we = 1'($urandom); bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_val = $urandom;
            bus.wb_we  = 1'($urandom); bus.wb_rd  = 5'($urandom_range(0, 3)); bus.wb_val  = $urandom;
            @(negedge clk);
            check_all("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
